count_checker: RTL and testbench

//  Receive-side checker for the free-running up-counter stream (count_o of the counter block).

---
 rtl/count_checker_pkg.sv | 19 +
 rtl/count_checker_sat_counter.sv | 22 ++
 rtl/count_checker.sv | 114 +++++++++++
 tb/tb_count_checker.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/count_checker_pkg.sv
// Shared types and default parameters for the count stream checker.
package count_checker_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } chk_state_t;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_ERR_CNT_W  = 8;

    // Enough bits to hold the values 0..lock_count.
    function automatic int match_cnt_width(input int lock_count);
        return $clog2(lock_count + 1);
    endfunction

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/count_checker.sv
// Receive-side checker for a free-running up-counter stream: hunts for alignment,
// locks after LOCK_COUNT consecutive +1 samples, then flags every break in the sequence.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     count_i,
    input  logic                 clear_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic                 wrap_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int MW = match_cnt_width(LOCK_COUNT);

    chk_state_t       state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [MW-1:0]    match_q, match_d;
    logic [MW-1:0]    match_inc;
    logic             in_seq;
    logic             err_d;
    logic             wrap_d;
    logic             locked_d;

    assign in_seq    = (count_i == expected_q);
    assign match_inc = match_q + MW'(1);

    // Next-state logic; clear takes priority over a valid sample in the same cycle.
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        match_d    = match_q;
        err_d      = 1'b0;
        wrap_d     = 1'b0;

        if (clear_i) begin
            state_d = HUNT;
            match_d = '0;
        end else if (valid_i) begin
            case (state_q)
                HUNT: begin
                    expected_d = count_i + WIDTH'(1);
                    match_d    = MW'(1);
                    state_d    = SYNC;
                end
                SYNC: begin
                    if (in_seq) begin
                        expected_d = expected_q + WIDTH'(1);
                        match_d    = match_inc;
                        if (match_inc == MW'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        expected_d = count_i + WIDTH'(1);
                        match_d    = MW'(1);
                    end
                end
                LOCKED: begin
                    if (in_seq) begin
                        expected_d = expected_q + WIDTH'(1);
                        wrap_d     = (count_i == '0);
                    end else begin
                        err_d      = 1'b1;
                        expected_d = count_i + WIDTH'(1);
                        match_d    = MW'(1);
                        state_d    = SYNC;
                    end
                end
                default: begin
                    state_d = HUNT;
                    match_d = '0;
                end
            endcase
        end
    end

    assign locked_d = (state_d == LOCKED);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= HUNT;
            expected_q <= '0;
            match_q    <= '0;
            locked_o   <= 1'b0;
            err_o      <= 1'b0;
            wrap_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            match_q    <= match_d;
            locked_o   <= locked_d;
            err_o      <= err_d;
            wrap_o     <= wrap_d;
        end
    end

    sat_counter #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc_i (err_d),
        .clr_i (clear_i),
        .cnt_o (err_count_o)
    );

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker: vector table, directed corner sequences and
// randomized traffic compared against a run-length reference model.
module tb_count_checker;

    localparam int LOCKN = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic [3:0] count;
    logic       clear;

    logic       locked, err, wrap;
    logic [7:0] err_count;
    logic       locked2, err2, wrap2;
    logic [1:0] err_count2;

    int tests  = 0;
    int failed = 0;

    // Reference model state: length of the current +1 chain, last sample, error tally.
    int         m_run  = 0;
    logic [3:0] m_last = '0;
    int         m_errs = 0;
    logic       m_lk = 1'b0, m_er = 1'b0, m_wr = 1'b0;

    typedef struct {
        logic       r;
        logic       v;
        logic [3:0] c;
        logic       cl;
        logic       lk;
        logic       er;
        logic       wr;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs[$];

    count_checker #(.WIDTH(4), .LOCK_COUNT(LOCKN), .ERR_CNT_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .count_i(count), .clear_i(clear),
        .locked_o(locked), .err_o(err), .wrap_o(wrap), .err_count_o(err_count)
    );

    count_checker #(.WIDTH(4), .LOCK_COUNT(LOCKN), .ERR_CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .count_i(count), .clear_i(clear),
        .locked_o(locked2), .err_o(err2), .wrap_o(wrap2), .err_count_o(err_count2)
    );

    always #5 clk = ~clk;

    function automatic void modelStep(input logic r, input logic v, input logic [3:0] c,
                                      input logic cl);
        logic was_locked;
        m_er = 1'b0;
        m_wr = 1'b0;
        if (!r || cl) begin
            m_run  = 0;
            m_errs = 0;
        end else if (v) begin
            was_locked = (m_run >= LOCKN);
            if (m_run == 0) begin
                m_run = 1;
            end else if (c == 4'((m_last + 1) % 16)) begin
                m_run = (m_run >= LOCKN) ? LOCKN : m_run + 1;
                m_wr  = was_locked && (c == 4'd0);
            end else begin
                m_run = 1;
                m_er  = was_locked;
                if (m_er) m_errs++;
            end
            m_last = c;
        end
        m_lk = (m_run >= LOCKN);
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] c,
                                 input logic cl);
        rst_n = r;
        valid = v;
        count = c;
        clear = cl;
        @(posedge clk);
        modelStep(r, v, c, cl);
        #1;
    endtask

    task automatic checkOne(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic lk, input logic er,
                               input logic wr, input int ec);
        int ec2;
        ec2 = (ec > 3) ? 3 : ec;
        checkOne({tag, ".locked"}, int'(locked), int'(lk));
        checkOne({tag, ".err"}, int'(err), int'(er));
        checkOne({tag, ".wrap"}, int'(wrap), int'(wr));
        checkOne({tag, ".err_count"}, int'(err_count), (ec > 255) ? 255 : ec);
        checkOne({tag, ".err_count_sat"}, int'(err_count2), ec2);
        checkOne({tag, ".err_sat"}, int'(err2), int'(er));
    endtask

    task automatic stepModel(input string tag, input logic r, input logic v,
                             input logic [3:0] c, input logic cl);
        applyStimulus(r, v, c, cl);
        checkOutput(tag, m_lk, m_er, m_wr, m_errs);
    endtask

    function automatic void addVec(input logic r, input logic v, input logic [3:0] c,
                                   input logic cl, input logic lk, input logic er,
                                   input logic wr, input logic [7:0] ec);
        vec_t t;
        t.r = r; t.v = v; t.c = c; t.cl = cl;
        t.lk = lk; t.er = er; t.wr = wr; t.ec = ec;
        vecs.push_back(t);
    endfunction

    initial begin
        logic [3:0] src;
        int         rnd;
        logic       rv, rc, rr;
        logic [3:0] cv;

        rst_n = 1'b0; valid = 1'b0; count = '0; clear = 1'b0;

        // Reset with noisy inputs, lock on 0..3, run through the wrap.
        addVec(0, 1, 4'd9, 0, 0, 0, 0, 0);
        addVec(0, 1, 4'd3, 1, 0, 0, 0, 0);
        addVec(1, 1, 4'd0, 0, 0, 0, 0, 0);
        addVec(1, 1, 4'd1, 0, 0, 0, 0, 0);
        addVec(1, 1, 4'd2, 0, 0, 0, 0, 0);
        addVec(1, 1, 4'd3, 0, 1, 0, 0, 0);
        for (int k = 4; k < 16; k++) addVec(1, 1, 4'(k), 0, 1, 0, 0, 0);
        addVec(1, 1, 4'd0, 0, 1, 0, 1, 0);
        addVec(1, 1, 4'd1, 0, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].r, vecs[i].v, vecs[i].c, vecs[i].cl);
            checkOutput($sformatf("vec%0d", i), vecs[i].lk, vecs[i].er, vecs[i].wr,
                        int'(vecs[i].ec));
        end

        // Break the locked sequence at 9 and relock on 9..12.
        for (int k = 2; k <= 6; k++) stepModel("seq", 1, 1, 4'(k), 0);
        stepModel("break9", 1, 1, 4'd9, 0);
        checkOne("break9.err_direct", int'(err), 1);
        checkOne("break9.locked_direct", int'(locked), 0);
        for (int k = 10; k <= 12; k++) stepModel("relock", 1, 1, 4'(k), 0);
        checkOne("relock12.locked_direct", int'(locked), 1);

        // Valid gaps with a stale count on the bus must not disturb alignment.
        stepModel("clr", 1, 0, 4'd0, 1);
        stepModel("gap0", 1, 1, 4'd0, 0);
        stepModel("gap1", 1, 1, 4'd1, 0);
        for (int k = 0; k < 3; k++) stepModel("gapidle", 1, 0, 4'd7, 0);
        stepModel("gap2", 1, 1, 4'd2, 0);
        stepModel("gap3", 1, 1, 4'd3, 0);
        checkOne("gap3.locked_direct", int'(locked), 1);

        // Five errors with relock between; the narrow counter saturates at 3.
        src = 4'd3;
        for (int e = 0; e < 5; e++) begin
            src = src + 4'd5;
            stepModel("inject", 1, 1, src, 0);
            checkOne("inject.err_sat_direct", int'(err_count2), (e + 1 > 3) ? 3 : e + 1);
            for (int k = 0; k < 3; k++) begin
                src = src + 4'd1;
                stepModel("relockN", 1, 1, src, 0);
            end
        end

        // Clear beats a bad sample while locked.
        stepModel("clrbad", 1, 1, src + 4'd7, 1);
        checkOne("clrbad.err_count_direct", int'(err_count), 0);
        for (int k = 0; k < 4; k++) begin
            src = src + 4'd1;
            stepModel("relockC", 1, 1, src, 0);
        end
        stepModel("midreset", 0, 1, src + 4'd1, 0);

        // Randomized traffic: mostly in-sequence with occasional jumps, stalls, clears, resets.
        src = 4'($urandom_range(0, 15));
        for (int n = 0; n < 3000; n++) begin
            rnd = int'($urandom_range(0, 999));
            rr  = (rnd >= 5);
            rc  = (rnd >= 5) && (rnd < 15);
            rv  = ($urandom_range(0, 99) < 80);
            rnd = int'($urandom_range(0, 99));
            if (rnd < 85)      cv = src + 4'd1;
            else if (rnd < 92) cv = src;
            else if (rnd < 95) cv = 4'd0;
            else               cv = 4'($urandom_range(0, 15));
            if (rv) src = cv;
            stepModel("rand", rr, rv, rv ? cv : 4'($urandom_range(0, 15)), rc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
